// File: rtl/status_branch_unit.sv
// rtl/status_branch_unit.sv - status flag register with conditional branch resolution
module status_branch_unit #(
    parameter int FORWARD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  alu_status,
    input  logic        alu_valid,
    input  logic        set_flags,
    input  logic        clr_sticky,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic [31:0] br_target,
    input  logic [31:0] pc_plus4,
    output logic [2:0]  flags,
    output logic        sticky_v,
    output logic        br_ack,
    output logic        take_branch,
    output logic        flush,
    output logic [31:0] next_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HAZ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        flag_wr;
    logic [2:0]  eff_flags;
    logic [2:0]  eval_flags;
    logic        latch_en;
    logic        decision;
    logic        take_q;

    // flags are {V,N,Z}; returns whether condition code c holds for f
    function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
        logic r;
        case (c)
            3'b000:  r = 1'b0;
            3'b001:  r = f[0];
            3'b010:  r = ~f[0];
            3'b011:  r = f[1];
            3'b100:  r = ~f[1];
            3'b101:  r = f[2];
            3'b110:  r = f[1] ^ f[2];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign flag_wr   = alu_valid & set_flags & ~stall;
    // with forwarding, a flag write in the same cycle is seen by the branch
    assign eff_flags = ((FORWARD != 0) && flag_wr) ? alu_status : flags;
    assign decision  = cond_true(br_cond, eval_flags);

    // next-state selection and decision latch enable
    always_comb begin
        state_nx   = state;
        latch_en   = 1'b0;
        eval_flags = eff_flags;
        case (state)
            IDLE: begin
                if (br_valid && !stall) begin
                    if ((FORWARD == 0) && flag_wr) begin
                        state_nx = HAZ;
                    end else begin
                        latch_en = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            HAZ: begin
                // flags register now holds the result of the earlier write
                if (!stall) begin
                    eval_flags = flags;
                    latch_en   = 1'b1;
                    state_nx   = RESP;
                end
            end
            RESP: begin
                if (!stall) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // flag register and sticky overflow; set beats clear
    always_ff @(posedge clk) begin
        if (reset) begin
            flags    <= 3'b000;
            sticky_v <= 1'b0;
        end else if (!stall) begin
            if (flag_wr) begin
                flags <= alu_status;
            end
            if (flag_wr && alu_status[2]) begin
                sticky_v <= 1'b1;
            end else if (clr_sticky) begin
                sticky_v <= 1'b0;
            end
        end
    end

    // latched branch decision and resolved PC, held until the next decision
    always_ff @(posedge clk) begin
        if (reset) begin
            take_q  <= 1'b0;
            next_pc <= 32'h0;
        end else if (latch_en) begin
            take_q  <= decision;
            next_pc <= decision ? {br_target[31:2], 2'b00} : pc_plus4;
        end
    end

    assign br_ack      = (state == RESP);
    assign take_branch = br_ack & take_q;
    assign flush       = br_ack & take_q;

endmodule
